// File: rtl/dct_block_sequencer_if.sv
// dct_block_sequencer_if
//   Coefficient hand-off channel from the DCT block sequencer to the
//   downstream quantiser/packer.
//   coef_out   : signed coefficient (OUT_W bits)
//   coef_k     : {k1,k2} index of coef_out
//   coef_valid : coefficient available
//   coef_ready : sink accepts when high together with coef_valid
//   master modport = sequencer side, slave modport = sink side.
interface dct_block_sequencer_if #(
    parameter int OUT_W = 16
);
    logic signed [OUT_W-1:0] coef_out;
    logic [5:0]              coef_k;
    logic                    coef_valid;
    logic                    coef_ready;

    modport master (output coef_out, coef_k, coef_valid, input coef_ready);
    modport slave  (input coef_out, coef_k, coef_valid, output coef_ready);
endinterface

// File: rtl/dct_block_sequencer.sv
// dct_block_sequencer
//   Sequences a full 8x8 2-D DCT over one pixel block. For each of the 64
//   (k1,k2) coefficients in raster order it walks the 64 (n1,n2) sample
//   positions, addresses the pixel buffer and cosine LUT bank, multiply-
//   accumulates pixel * cos_term, and hands the scaled, saturated result to
//   the coefficient sink over a valid/ready channel.
//
//   Ports:
//     clk, reset            : clock, synchronous active-high reset
//     start                 : begin a block (sampled in IDLE only)
//     busy / done           : not-IDLE flag / one-cycle end-of-block pulse
//     pix_addr, pix_data    : pixel buffer address {n1,n2}, data one cycle later
//     lut_k1..lut_n2        : cosine LUT indices
//     cos_term              : signed LUT output, combinational from lut_*
//     coef (interface)      : coef_out / coef_k / coef_valid / coef_ready
//
//   Build option: define DCT_LEVEL_SHIFT_EN to subtract 2^(PIX_W-1) from each
//   pixel before the multiply (centred, JPEG-style transform). Timing and
//   interface are identical in both builds.
module dct_block_sequencer #(
    parameter int PIX_W     = 8,
    parameter int COS_W     = 32,
    parameter int ACC_W     = 32,
    parameter int FRAC_BITS = 8,
    parameter int OUT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [5:0]              pix_addr,
    input  logic [PIX_W-1:0]        pix_data,
    output logic [2:0]              lut_k1,
    output logic [2:0]              lut_k2,
    output logic [2:0]              lut_n1,
    output logic [2:0]              lut_n2,
    input  logic signed [COS_W-1:0] cos_term,
    dct_block_sequencer_if.master   coef
);
    localparam int PROD_W = PIX_W + 1 + COS_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [5:0]              k_q, k_d;
    logic [5:0]              idx_q, idx_d;
    logic signed [COS_W-1:0] cos_q, cos_d;
    logic                    mac_en_q, mac_en_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [OUT_W-1:0] coef_q, coef_d;

    logic signed [PIX_W:0]   pix_s;
    logic signed [ACC_W-1:0] prod_t;
    logic signed [ACC_W-1:0] mac_sum;
    logic signed [ACC_W-1:0] acc_shr;

    // Pixel as a signed PIX_W+1 operand.
`ifdef DCT_LEVEL_SHIFT_EN
    localparam logic [PIX_W:0] LVL_OFF = {2'b01, {(PIX_W-1){1'b0}}};
    always_comb pix_s = $signed({1'b0, pix_data} - LVL_OFF);
`else
    always_comb pix_s = $signed({1'b0, pix_data});
`endif

    // Product is taken at full width and truncated; the accumulator wraps.
    always_comb begin
        prod_t  = ACC_W'(PROD_W'(pix_s) * PROD_W'(cos_q));
        mac_sum = acc_q + prod_t;
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        idx_d    = idx_q;
        cos_d    = cos_q;
        mac_en_d = 1'b0;
        // pix_data for the address issued last cycle arrives now, alongside
        // the cos_term registered on that same edge.
        acc_d    = mac_en_q ? mac_sum : acc_q;
        coef_d   = coef_q;
        acc_shr  = acc_d >>> FRAC_BITS;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    k_d     = '0;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            S_RUN: begin
                cos_d    = cos_term;
                mac_en_d = 1'b1;
                if (idx_q == 6'd63) state_d = S_DRAIN;
                else                idx_d   = idx_q + 6'd1;
            end
            S_DRAIN: begin
                // acc_d already includes the final product here.
                if (acc_shr > SAT_MAX)      coef_d = OUT_W'(SAT_MAX);
                else if (acc_shr < SAT_MIN) coef_d = OUT_W'(SAT_MIN);
                else                        coef_d = acc_shr[OUT_W-1:0];
                state_d = S_OUT;
            end
            S_OUT: begin
                if (coef.coef_ready) begin
                    idx_d = '0;
                    if (k_q == 6'd63) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + 6'd1;
                        acc_d   = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            idx_q    <= '0;
            cos_q    <= '0;
            mac_en_q <= 1'b0;
            acc_q    <= '0;
            coef_q   <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            idx_q    <= idx_d;
            cos_q    <= cos_d;
            mac_en_q <= mac_en_d;
            acc_q    <= acc_d;
            coef_q   <= coef_d;
        end
    end

    always_comb begin
        busy            = (state_q != S_IDLE);
        done            = (state_q == S_DONE);
        pix_addr        = idx_q;
        lut_k1          = k_q[5:3];
        lut_k2          = k_q[2:0];
        lut_n1          = idx_q[5:3];
        lut_n2          = idx_q[2:0];
        coef.coef_valid = (state_q == S_OUT);
        coef.coef_out   = coef_q;
        coef.coef_k     = k_q;
    end
endmodule

// File: tb/tb_dct_block_sequencer.sv
module tb_dct_block_sequencer;
    localparam int PIX_W = 8, COS_W = 32, ACC_W = 32, FRAC_BITS = 8, OUT_W = 16;

    logic clk = 1'b0;
    logic reset, start, busy, done;
    logic [5:0] pix_addr;
    logic [PIX_W-1:0] pix_data;
    logic [2:0] lut_k1, lut_k2, lut_n1, lut_n2;
    logic signed [COS_W-1:0] cos_term;

    always #5 clk = ~clk;

    dct_block_sequencer_if #(.OUT_W(OUT_W)) cif();

    dct_block_sequencer #(
        .PIX_W(PIX_W), .COS_W(COS_W), .ACC_W(ACC_W),
        .FRAC_BITS(FRAC_BITS), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .pix_addr(pix_addr), .pix_data(pix_data),
        .lut_k1(lut_k1), .lut_k2(lut_k2), .lut_n1(lut_n1), .lut_n2(lut_n2),
        .cos_term(cos_term), .coef(cif)
    );

    // Bench-side pixel buffer and LUT bank.
    logic [7:0] pix_mem [64];
    int real_lut [4096];
    int lut_mode;   // 0: constant, 1: real orthonormal DCT table
    int lut_const;

    always @(posedge clk) pix_data <= pix_mem[pix_addr];

    always_comb begin
        cos_term = lut_const;
        if (lut_mode != 0) cos_term = real_lut[{lut_k1, lut_k2, lut_n1, lut_n2}];
    end

    int checks = 0, errors = 0;
    int done_cnt = 0, busy_cnt = 0;

    typedef struct { int k; int v; } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int lut_val(input int k, input int n);
        if (lut_mode != 0) return real_lut[k*64 + n];
        return lut_const;
    endfunction

    // Golden model: wrap at 32 bits, arithmetic shift, saturate to 16 bits.
    function automatic int model_coef(input int k);
        longint acc = 0, p, sh;
        for (int n = 0; n < 64; n++) begin
            p = longint'(pix_mem[n]);
`ifdef DCT_LEVEL_SHIFT_EN
            p = p - 128;
`endif
            acc = longint'(int'(acc + p * longint'(lut_val(k, n))));
        end
        sh = acc >>> FRAC_BITS;
        if (sh > 32767) sh = 32767;
        if (sh < -32768) sh = -32768;
        return int'(sh);
    endfunction

    task automatic push_block();
        exp_t e;
        for (int k = 0; k < 64; k++) begin
            e.k = k;
            e.v = model_coef(k);
            exp_q.push_back(e);
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (cif.coef_valid && cif.coef_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_coef", longint'(cif.coef_k), -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("coef_k", longint'(cif.coef_k), longint'(e.k));
                    chk("coef_out", longint'($signed(cif.coef_out)), longint'(e.v));
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_coef_valid"}, longint'(cif.coef_valid), 0);
        chk({tag, "_coef_out"}, longint'(cif.coef_out), 0);
        chk({tag, "_coef_k"}, longint'(cif.coef_k), 0);
        chk({tag, "_pix_addr"}, longint'(pix_addr), 0);
        chk({tag, "_lut"}, longint'({lut_k1, lut_k2, lut_n1, lut_n2}), 0);
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; return; end
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic run_block(input string tag, input bit stall, input bit poke);
        bit ok;
        int d0;
        push_block();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        busy_cnt = 0;
        d0 = done_cnt;
        fork
            begin
                wait_done(6000, ok);
                @(negedge clk);
            end
            begin
                if (poke) begin
                    repeat (20) @(posedge clk);
                    #1 start = 1'b1;
                    @(posedge clk); #1 start = 1'b0;
                end
                if (stall) begin
                    bit found = 1'b0;
                    logic [OUT_W-1:0] c0;
                    logic [5:0] a0;
                    for (int c = 0; c < 1000; c++) begin
                        @(posedge clk); #1;
                        if (cif.coef_valid && cif.coef_k == 6'd5) begin found = 1'b1; break; end
                    end
                    chk("stall_reached", longint'(found), 1);
                    if (found) begin
                        cif.coef_ready = 1'b0;
                        c0 = cif.coef_out;
                        a0 = pix_addr;
                        repeat (10) begin
                            @(negedge clk);
                            if (cif.coef_valid !== 1'b1 || cif.coef_k !== 6'd5 ||
                                cif.coef_out !== c0 || pix_addr !== a0)
                                chk("stall_stable", 0, 1);
                            else
                                chk("stall_stable", 1, 1);
                        end
                        @(posedge clk); #1 cif.coef_ready = 1'b1;
                    end
                end
            end
        join
        chk({tag, "_busy_cycles"}, longint'(busy_cnt), stall ? 64*66 + 1 + 10 : 64*66 + 1);
        chk({tag, "_done_pulses"}, longint'(done_cnt - d0), 1);
        chk({tag, "_queue_empty"}, longint'(exp_q.size()), 0);
    endtask

    initial begin
        real pi, a1, a2, x;
        bit ok, found;
        pi = 3.14159265358979;
        for (int k1 = 0; k1 < 8; k1++)
            for (int k2 = 0; k2 < 8; k2++)
                for (int n1 = 0; n1 < 8; n1++)
                    for (int n2 = 0; n2 < 8; n2++) begin
                        a1 = (k1 == 0) ? $sqrt(0.125) : 0.5;
                        a2 = (k2 == 0) ? $sqrt(0.125) : 0.5;
                        x = 256.0 * a1 * a2 * $cos((2*n1 + 1) * k1 * pi / 16.0)
                                            * $cos((2*n2 + 1) * k2 * pi / 16.0);
                        real_lut[(k1*8 + k2)*64 + n1*8 + n2] =
                            (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
                    end

        reset = 1'b1; start = 1'b0; cif.coef_ready = 1'b1;
        lut_mode = 0; lut_const = 256;
        for (int n = 0; n < 64; n++) pix_mem[n] = 8'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        #1 reset = 1'b0;

        // Unit LUT, unit pixels; also start pulsed while busy.
        run_block("unit", 1'b0, 1'b1);

        // Saturation at both rails.
        lut_const = 32767;
        for (int n = 0; n < 64; n++) pix_mem[n] = 8'd255;
        run_block("sat_pos", 1'b0, 1'b0);
        lut_const = -32768;
        run_block("sat_neg", 1'b0, 1'b0);

        // Real DCT table on a flat block.
        lut_mode = 1;
        for (int n = 0; n < 64; n++) pix_mem[n] = 8'd128;
        run_block("flat128", 1'b0, 1'b0);

        // Textured block with backpressure at k=5.
        for (int n = 0; n < 64; n++) pix_mem[n] = 8'((n * 37 + 11) & 255);
        run_block("stall", 1'b1, 1'b0);

        // Back-to-back blocks with start held high.
        push_block();
        push_block();
        @(posedge clk); #1 start = 1'b1;
        wait_done(6000, ok);
        if (ok) begin
            @(negedge clk); chk("b2b_idle_gap", longint'(busy), 0);
            @(negedge clk); chk("b2b_restart", longint'(busy), 1);
        end
        start = 1'b0;
        wait_done(6000, ok);
        @(negedge clk);
        chk("b2b_queue_empty", longint'(exp_q.size()), 0);

        // Reset mid-RUN at k=3, idx=17, then a clean block.
        push_block();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            if (busy && cif.coef_k == 6'd3 && pix_addr == 6'd17) begin found = 1'b1; break; end
        end
        chk("midrun_reached", longint'(found), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("midrun_reset");
        exp_q.delete();
        reset = 1'b0;
        run_block("post_reset", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
